// File: rtl/alu_exec_stage.sv
// Single-issue ALU execute stage: one-cycle ALU ops, 16-cycle shift-add multiply,
// registered result/flags with a one-cycle register-file write pulse.
module alu_exec_stage #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              Clear,
   input  logic              start,
   input  logic [3:0]        op,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   input  logic [ADDR_W-1:0] dest,
   output logic [DATA_W-1:0] C,
   output logic [ADDR_W-1:0] Caddr,
   output logic              Load,
   output logic              busy,
   output logic              illegal,
   output logic              zero,
   output logic              carry,
   output logic              ovf
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_MUL
   } state_t;

   typedef enum logic [3:0] {
      OP_ADD   = 4'd0,
      OP_SUB   = 4'd1,
      OP_AND   = 4'd2,
      OP_OR    = 4'd3,
      OP_XOR   = 4'd4,
      OP_NOR   = 4'd5,
      OP_SLT   = 4'd6,
      OP_SLL   = 4'd7,
      OP_SRL   = 4'd8,
      OP_SRA   = 4'd9,
      OP_MUL   = 4'd10,
      OP_PASSB = 4'd11
   } op_t;

   state_t            r_state;
   state_t            w_state_next;
   logic [3:0]        r_op;
   logic [DATA_W-1:0] r_a;
   logic [DATA_W-1:0] r_b;
   logic [ADDR_W-1:0] r_dest;
   logic [4:0]        r_cnt;
   logic [DATA_W-1:0] r_prod;

   logic              w_accept;
   logic              w_legal;
   logic [DATA_W:0]   w_sum;
   logic [DATA_W:0]   w_diff;
   logic [3:0]        w_shamt;
   logic [DATA_W-1:0] w_alu;
   logic              w_cy;
   logic              w_ov;
   logic [DATA_W-1:0] w_prod_next;
   logic              w_mul_last;

   always_ff @(posedge clk) begin
      if (Clear) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      busy         = (r_state != S_IDLE);
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_next = (op == OP_MUL) ? S_MUL : S_EXEC;
            end
         end
         S_EXEC:  w_state_next = S_IDLE;
         S_MUL: begin
            if (w_mul_last) begin
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   assign w_accept    = (r_state == S_IDLE) && start;
   assign w_legal     = (r_op < 4'd12);
   assign w_sum       = {1'b0, r_a} + {1'b0, r_b};
   assign w_diff      = {1'b0, r_a} - {1'b0, r_b};
   assign w_shamt     = r_b[3:0];
   assign w_mul_last  = (r_cnt == 5'd15);
   // One partial product per cycle; only the low DATA_W bits are ever kept
   assign w_prod_next = r_prod + (r_b[r_cnt[3:0]] ? (r_a << r_cnt[3:0]) : '0);

   always_comb begin
      w_alu = '0;
      w_cy  = 1'b0;
      w_ov  = 1'b0;
      case (r_op)
         OP_ADD: begin
            w_alu = w_sum[DATA_W-1:0];
            w_cy  = w_sum[DATA_W];
            w_ov  = (r_a[DATA_W-1] == r_b[DATA_W-1]) &&
                    (w_sum[DATA_W-1] != r_a[DATA_W-1]);
         end
         OP_SUB: begin
            w_alu = w_diff[DATA_W-1:0];
            w_cy  = w_diff[DATA_W];
            w_ov  = (r_a[DATA_W-1] != r_b[DATA_W-1]) &&
                    (w_diff[DATA_W-1] != r_a[DATA_W-1]);
         end
         OP_AND:   w_alu = r_a & r_b;
         OP_OR:    w_alu = r_a | r_b;
         OP_XOR:   w_alu = r_a ^ r_b;
         OP_NOR:   w_alu = ~(r_a | r_b);
         OP_SLT:   w_alu = {{(DATA_W-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
         OP_SLL:   w_alu = r_a << w_shamt;
         OP_SRL:   w_alu = r_a >> w_shamt;
         OP_SRA:   w_alu = $signed(r_a) >>> w_shamt;
         OP_PASSB: w_alu = r_b;
         default:  w_alu = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (Clear) begin
         C       <= '0;
         Caddr   <= '0;
         Load    <= 1'b0;
         illegal <= 1'b0;
         zero    <= 1'b0;
         carry   <= 1'b0;
         ovf     <= 1'b0;
         r_op    <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_dest  <= '0;
         r_cnt   <= '0;
         r_prod  <= '0;
      end else begin
         Load    <= 1'b0;
         illegal <= 1'b0;
         if (w_accept) begin
            r_op   <= op;
            r_a    <= A;
            r_b    <= B;
            r_dest <= dest;
            r_cnt  <= '0;
            r_prod <= '0;
         end
         case (r_state)
            S_EXEC: begin
               // Reserved ops leave result, address and flags untouched
               if (w_legal) begin
                  C     <= w_alu;
                  Caddr <= r_dest;
                  Load  <= 1'b1;
                  zero  <= (w_alu == '0);
                  carry <= w_cy;
                  ovf   <= w_ov;
               end else begin
                  illegal <= 1'b1;
               end
            end
            S_MUL: begin
               r_prod <= w_prod_next;
               r_cnt  <= r_cnt + 5'd1;
               if (w_mul_last) begin
                  C     <= w_prod_next;
                  Caddr <= r_dest;
                  Load  <= 1'b1;
                  zero  <= (w_prod_next == '0);
                  carry <= 1'b0;
                  ovf   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: ALU vectors, multiply timing, mid-op Clear
// and reserved-op handling, all against hand-computed values.
module tb_alu_exec_stage;

   logic        clk;
   logic        Clear;
   logic        start;
   logic [3:0]  op;
   logic [15:0] A;
   logic [15:0] B;
   logic [3:0]  dest;
   logic [15:0] C;
   logic [3:0]  Caddr;
   logic        Load;
   logic        busy;
   logic        illegal;
   logic        zero;
   logic        carry;
   logic        ovf;

   int n_total = 0;
   int n_bad   = 0;

   alu_exec_stage #(.DATA_W(16), .ADDR_W(4)) u_dut (
      .clk     (clk),
      .Clear   (Clear),
      .start   (start),
      .op      (op),
      .A       (A),
      .B       (B),
      .dest    (dest),
      .C       (C),
      .Caddr   (Caddr),
      .Load    (Load),
      .busy    (busy),
      .illegal (illegal),
      .zero    (zero),
      .carry   (carry),
      .ovf     (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one ALU op in the current (idle) cycle and check its completion.
   task automatic run_alu(input string tag, input logic [3:0] o, input logic [15:0] a,
                          input logic [15:0] b, input logic [3:0] d, input logic [15:0] ec,
                          input logic ez, input logic ecy, input logic eov);
      op = o; A = a; B = b; dest = d; start = 1'b1;
      tick();
      start = 1'b0;
      check({tag, ".busy"}, busy, 1);
      check({tag, ".load0"}, Load, 0);
      check({tag, ".ill0"}, illegal, 0);
      tick();
      check({tag, ".load"}, Load, 1);
      check({tag, ".C"}, C, ec);
      check({tag, ".Caddr"}, Caddr, d);
      check({tag, ".zero"}, zero, ez);
      check({tag, ".carry"}, carry, ecy);
      check({tag, ".ovf"}, ovf, eov);
      check({tag, ".idle"}, busy, 0);
   endtask

   initial begin
      Clear = 1'b1; start = 1'b0; op = '0; A = '0; B = '0; dest = '0;
      tick();
      tick();
      check("rst.C", C, 0);
      check("rst.Caddr", Caddr, 0);
      check("rst.load", Load, 0);
      check("rst.busy", busy, 0);
      check("rst.ill", illegal, 0);
      check("rst.flags", {zero, carry, ovf}, 0);
      Clear = 1'b0;

      run_alu("add_wrap", 4'd0, 16'hFFFF, 16'h0001, 4'd3, 16'h0000, 1, 1, 0);
      run_alu("sub_ovf",  4'd1, 16'h8000, 16'h0001, 4'd2, 16'h7FFF, 0, 0, 1);
      run_alu("slt",      4'd6, 16'hFFFF, 16'h0001, 4'd4, 16'h0001, 0, 0, 0);
      run_alu("and",      4'd2, 16'hF0F0, 16'h3C3C, 4'd5, 16'h3030, 0, 0, 0);
      run_alu("or",       4'd3, 16'hF0F0, 16'h3C3C, 4'd6, 16'hFCFC, 0, 0, 0);
      run_alu("xor",      4'd4, 16'hF0F0, 16'h3C3C, 4'd7, 16'hCCCC, 0, 0, 0);
      run_alu("nor",      4'd5, 16'hF0F0, 16'h3C3C, 4'd8, 16'h0303, 0, 0, 0);
      run_alu("sll",      4'd7, 16'h0001, 16'h0013, 4'd9, 16'h0008, 0, 0, 0);
      run_alu("srl",      4'd8, 16'h8000, 16'h0004, 4'd10, 16'h0800, 0, 0, 0);
      run_alu("sra",      4'd9, 16'h8000, 16'h0004, 4'd11, 16'hF800, 0, 0, 0);
      run_alu("passb_d0", 4'd11, 16'h5555, 16'h1234, 4'd0, 16'h1234, 0, 0, 0);
      run_alu("sub_brw",  4'd1, 16'h0001, 16'h0002, 4'd12, 16'hFFFF, 0, 1, 0);
      run_alu("add_ovf",  4'd0, 16'h7FFF, 16'h0001, 4'd13, 16'h8000, 0, 0, 1);

      // Multiply with start pulses arriving while busy
      op = 4'd10; A = 16'h0123; B = 16'h0045; dest = 4'd7; start = 1'b1;
      tick();
      start = 1'b0;
      check("mul.busy0", busy, 1);
      for (int i = 1; i <= 16; i++) begin
         if (i == 4) begin
            start = 1'b1; op = 4'd0; A = 16'h0001; B = 16'h0001; dest = 4'd9;
         end
         if (i == 6) start = 1'b0;
         tick();
         if (i < 16) begin
            check("mul.busy", busy, 1);
            check("mul.noload", Load, 0);
         end else begin
            check("mul.load", Load, 1);
            check("mul.C", C, 16'h4E6F);
            check("mul.Caddr", Caddr, 7);
            check("mul.zero", zero, 0);
            check("mul.idle", busy, 0);
         end
      end
      tick();
      check("mul.load_once", Load, 0);
      check("mul.hold_C", C, 16'h4E6F);
      check("mul.no_extra", busy, 0);

      // Clear in the middle of a multiply
      op = 4'd10; A = 16'h0123; B = 16'h0045; dest = 4'd5; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         tick();
         check("mclr.busy", busy, 1);
         check("mclr.noload", Load, 0);
      end
      Clear = 1'b1;
      tick();
      check("mclr.idle", busy, 0);
      check("mclr.C", C, 0);
      check("mclr.Caddr", Caddr, 0);
      check("mclr.load", Load, 0);
      check("mclr.flags", {zero, carry, ovf, illegal}, 0);
      start = 1'b1; op = 4'd0; A = 16'h0007; B = 16'h0001; dest = 4'd2;
      tick();
      check("clrprio.busy", busy, 0);
      check("clrprio.load", Load, 0);
      Clear = 1'b0; start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("mclr.quiet", Load, 0);
      end
      run_alu("post_clr", 4'd0, 16'h0002, 16'h0003, 4'd1, 16'h0005, 0, 0, 0);

      // Reserved op leaves result and flags alone; following ADD issued back-to-back
      run_alu("pre_ill", 4'd0, 16'hFFFF, 16'h0002, 4'd6, 16'h0001, 0, 1, 0);
      op = 4'd13; A = 16'h0005; B = 16'h0005; dest = 4'd2; start = 1'b1;
      tick();
      start = 1'b0;
      check("ill.busy", busy, 1);
      check("ill.pre", illegal, 0);
      tick();
      check("ill.pulse", illegal, 1);
      check("ill.noload", Load, 0);
      check("ill.C", C, 16'h0001);
      check("ill.Caddr", Caddr, 6);
      check("ill.flags", {zero, carry, ovf}, 3'b010);
      check("ill.idle", busy, 0);
      run_alu("after_ill", 4'd0, 16'h0002, 16'h0003, 4'd4, 16'h0005, 0, 0, 0);
      tick();
      check("end.load0", Load, 0);
      check("end.ill0", illegal, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
